// File: rtl/fetch_pc_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fetch_pc_sequencer
//
// Instruction-fetch controller for the IF stage. It owns the program counter
// (pc) and the address of the instruction currently held for decode
// (past_pc). It issues instruction-memory requests over a req/ack handshake
// and buffers one fetched instruction until decode accepts it. It also
// redirects on taken branches. A branch that arrives while a request is still
// outstanding is deferred: the outstanding address stays stable, and the data
// that returns for it is thrown away.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   pipe_stall        decode cannot accept the held instruction this cycle
//   branch_taken      one-cycle redirect request
//   branch_target     redirect address, sampled with branch_taken
//   im_req            instruction-memory request (registered)
//   im_addr           request address, always equal to pc
//   im_ack            memory returns data this cycle (meaningful with im_req)
//   im_rdata          fetched instruction, valid with im_ack
//   pc                address of the next or outstanding fetch
//   past_pc           address of the instruction on instr_out
//   instr_out         held instruction, NOP_INSTR when nothing is held
//   instr_valid       instr_out holds a live instruction
//   bus_stall         request outstanding with no ack this cycle (comb)
//   instruction_stall live instruction blocked by pipe_stall (comb)
//   bus_err           sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module fetch_pc_sequencer #(
    parameter int                   DATA_SIZE = 32,
    parameter logic [DATA_SIZE-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DATA_SIZE-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int                   TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_stall,
    input  logic                 branch_taken,
    input  logic [DATA_SIZE-1:0] branch_target,
    output logic                 im_req,
    output logic [DATA_SIZE-1:0] im_addr,
    input  logic                 im_ack,
    input  logic [DATA_SIZE-1:0] im_rdata,
    output logic [DATA_SIZE-1:0] pc,
    output logic [DATA_SIZE-1:0] past_pc,
    output logic [DATA_SIZE-1:0] instr_out,
    output logic                 instr_valid,
    output logic                 bus_stall,
    output logic                 instruction_stall,
    output logic                 bus_err
);

    // Watchdog counter just wide enough to hold TIMEOUT, at least one bit.
    localparam int                   CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     WAIT_MAX = CNT_W'(TIMEOUT);
    localparam logic [DATA_SIZE-1:0] PC_STEP  = DATA_SIZE'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_VALID
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] pc_q, pc_d;
    logic [DATA_SIZE-1:0] past_pc_q, past_pc_d;
    logic [DATA_SIZE-1:0] instr_q, instr_d;
    logic                 valid_q, valid_d;
    logic                 req_q, req_d;
    logic                 bus_err_q, bus_err_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [DATA_SIZE-1:0] tgt_buf_q, tgt_buf_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            past_pc_q    <= RESET_PC;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
            req_q        <= 1'b0;
            bus_err_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            tgt_buf_q    <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            past_pc_q    <= past_pc_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            req_q        <= req_d;
            bus_err_q    <= bus_err_d;
            flush_pend_q <= flush_pend_d;
            tgt_buf_q    <= tgt_buf_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Priority: branch_taken > im_ack > pipe_stall.
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default before the case statement, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        past_pc_d    = past_pc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        bus_err_d    = bus_err_q;
        flush_pend_d = flush_pend_q;
        tgt_buf_d    = tgt_buf_q;
        wait_cnt_d   = '0;          // cleared whenever we are not waiting in S_FETCH

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (im_ack) begin
                    if (branch_taken || flush_pend_q) begin
                        // The returning data belongs to the abandoned path.
                        // Re-aim and issue the new request next cycle.
                        pc_d         = branch_taken ? branch_target : tgt_buf_q;
                        flush_pend_d = 1'b0;
                    end else begin
                        instr_d   = im_rdata;
                        valid_d   = 1'b1;
                        past_pc_d = pc_q;
                        pc_d      = pc_q + PC_STEP;
                        state_d   = S_VALID;
                    end
                end else begin
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                                          : wait_cnt_q + CNT_W'(1);
                    if (wait_cnt_d == WAIT_MAX) begin
                        bus_err_d = 1'b1;
                    end
                    // The outstanding address must not move, so the redirect
                    // is parked until the ack for the current address arrives.
                    if (branch_taken) begin
                        flush_pend_d = 1'b1;
                        tgt_buf_d    = branch_target;
                    end
                end
            end

            S_VALID: begin
                if (branch_taken) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    pc_d    = branch_target;
                    state_d = S_FETCH;
                end else if (!pipe_stall) begin
                    // Consumed by decode. Fall back to NOP while nothing is held.
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // im_req is registered: it is high for exactly the cycles spent in
        // S_FETCH.
        req_d = (state_d == S_FETCH);
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign im_req            = req_q;
    assign im_addr           = pc_q;
    assign pc                = pc_q;
    assign past_pc           = past_pc_q;
    assign instr_out         = instr_q;
    assign instr_valid       = valid_q;
    assign bus_err           = bus_err_q;
    assign bus_stall         = req_q & ~im_ack;
    assign instruction_stall = valid_q & pipe_stall;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fetch_pc_sequencer
//
// Directed bench for fetch_pc_sequencer. It steps the design one clock at a
// time. Inputs change 1 ns after the rising edge, and outputs are compared
// against hand-computed values before the next edge.
// ---------------------------------------------------------------------------
module tb_fetch_pc_sequencer;

    localparam int          W   = 32;
    localparam logic [W-1:0] NOP = 32'h0000_0013;

    logic         clk;
    logic         rst;
    logic         pipe_stall;
    logic         branch_taken;
    logic [W-1:0] branch_target;
    logic         im_req;
    logic [W-1:0] im_addr;
    logic         im_ack;
    logic [W-1:0] im_rdata;
    logic [W-1:0] pc;
    logic [W-1:0] past_pc;
    logic [W-1:0] instr_out;
    logic         instr_valid;
    logic         bus_stall;
    logic         instruction_stall;
    logic         bus_err;

    int tests = 0;
    int fails = 0;

    fetch_pc_sequencer #(
        .DATA_SIZE (W),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP),
        .TIMEOUT   (15)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pipe_stall        (pipe_stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .im_req            (im_req),
        .im_addr           (im_addr),
        .im_ack            (im_ack),
        .im_rdata          (im_rdata),
        .pc                (pc),
        .past_pc           (past_pc),
        .instr_out         (instr_out),
        .instr_valid       (instr_valid),
        .bus_stall         (bus_stall),
        .instruction_stall (instruction_stall),
        .bus_err           (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst           = 1'b0;
        pipe_stall    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        im_ack        = 1'b0;
        im_rdata      = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",      pc,          32'h0);
        check("rst_past_pc", past_pc,     32'h0);
        check("rst_instr",   instr_out,   NOP);
        check("rst_valid",   instr_valid, 1'b0);
        check("rst_req",     im_req,      1'b0);
        check("rst_bus_err", bus_err,     1'b0);

        // ---------------- zero-wait streaming ----------------
        rst    = 1'b1;
        im_ack = 1'b1;
        check("a_req_cycle1", im_req, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            im_rdata = 32'hA5A5_0000 + 32'(k);
            check("a_fetch_req",   im_req,      1'b1);
            check("a_fetch_addr",  im_addr,     32'(4 * k));
            check("a_fetch_valid", instr_valid, 1'b0);
            step();
            check("a_valid",   instr_valid, 1'b1);
            check("a_instr",   instr_out,   32'hA5A5_0000 + 32'(k));
            check("a_past_pc", past_pc,     32'(4 * k));
            check("a_pc",      pc,          32'(4 * k + 4));
            check("a_req_off", im_req,      1'b0);
            if (k < 3) step();
        end

        // ---------------- three wait cycles at 0x10 ----------------
        im_ack = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("b_bus_stall", bus_stall, 1'b1);
            check("b_addr_held", im_addr,   32'h10);
            check("b_pc_held",   pc,        32'h10);
            step();
        end
        im_ack   = 1'b1;
        im_rdata = 32'hC0FF_EE01;
        #1;
        check("b_stall_on_ack", bus_stall, 1'b0);
        step();
        check("b_valid",   instr_valid, 1'b1);
        check("b_instr",   instr_out,   32'hC0FF_EE01);
        check("b_past_pc", past_pc,     32'h10);
        check("b_pc",      pc,          32'h14);

        // ---------------- decode stall for four cycles ----------------
        pipe_stall = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("c_instr_stall", instruction_stall, 1'b1);
            check("c_instr_held",  instr_out,         32'hC0FF_EE01);
            check("c_past_held",   past_pc,           32'h10);
            check("c_pc_held",     pc,                32'h14);
            check("c_req_off",     im_req,            1'b0);
            if (i < 3) step();
        end
        pipe_stall = 1'b0;
        step();
        check("c_release_valid", instr_valid,       1'b0);
        check("c_release_req",   im_req,            1'b1);
        check("c_release_addr",  im_addr,           32'h14);
        check("c_release_stall", instruction_stall, 1'b0);

        // ---------------- deferred branch while waiting at 0x20 ----------------
        repeat (6) step();
        im_ack = 1'b0;
        check("d_wait_addr", im_addr, 32'h20);
        check("d_wait_req",  im_req,  1'b1);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken  = 1'b0;
        branch_target = 32'hDEAD_BEEF;
        check("d_addr_stable", im_addr,     32'h20);
        check("d_no_valid",    instr_valid, 1'b0);
        step();
        check("d_pc_stable", pc, 32'h20);
        im_ack   = 1'b1;
        im_rdata = 32'hBAD0_BAD0;
        step();
        check("d_discard_valid", instr_valid, 1'b0);
        check("d_discard_past",  past_pc,     32'h1C);
        check("d_redirect_req",  im_req,      1'b1);
        check("d_redirect_addr", im_addr,     32'h100);
        im_rdata = 32'h5555_0001;
        step();
        check("d_new_instr", instr_out, 32'h5555_0001);
        check("d_new_past",  past_pc,   32'h100);
        check("d_new_pc",    pc,        32'h104);

        // ---------------- branch in S_VALID under pipe_stall ----------------
        pipe_stall    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        #1;
        check("e_instr_stall", instruction_stall, 1'b1);
        step();
        pipe_stall   = 1'b0;
        branch_taken = 1'b0;
        check("e_valid", instr_valid, 1'b0);
        check("e_instr", instr_out,   NOP);
        check("e_pc",    pc,          32'h200);
        check("e_addr",  im_addr,     32'h200);
        check("e_req",   im_req,      1'b1);

        // ---------------- watchdog ----------------
        im_ack = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14 || i == 15 || i == 20) begin
                check("f_bus_err", bus_err, (i >= 15) ? 1'b1 : 1'b0);
                check("f_req_on",  im_req,  1'b1);
            end
        end
        im_ack   = 1'b1;
        im_rdata = 32'h7777_0002;
        step();
        check("f_ack_valid",   instr_valid, 1'b1);
        check("f_ack_past",    past_pc,     32'h200);
        check("f_err_sticky",  bus_err,     1'b1);
        im_ack = 1'b0;
        repeat (3) step();
        check("f_wait_req", im_req, 1'b1);
        check("f_wait_pc",  pc,     32'h204);

        // ---------------- asynchronous reset mid-wait ----------------
        #2;
        rst = 1'b0;
        #1;
        check("g_bus_err", bus_err,     1'b0);
        check("g_req",     im_req,      1'b0);
        check("g_pc",      pc,          32'h0);
        check("g_past",    past_pc,     32'h0);
        check("g_valid",   instr_valid, 1'b0);
        check("g_instr",   instr_out,   NOP);
        im_ack = 1'b1;
        step();
        check("g_hold_req", im_req, 1'b0);
        check("g_hold_pc",  pc,     32'h0);
        rst = 1'b1;
        step();
        check("g_restart_req",  im_req,  1'b1);
        check("g_restart_addr", im_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Instruction-fetch controller for the CPU IF stage.
- Owns the PC and past_PC registers and issues instruction-memory requests over a req/ack handshake.
- Buffers one fetched instruction until the decode stage accepts it, and redirects on taken branches.
- Generates the bus_stall and instruction_stall conditions consumed by the PC-select logic and the pipeline.

Parameters:
- DATA_SIZE, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_out when no valid instruction is held.
- TIMEOUT, 15, number of consecutive unacknowledged request cycles before bus_err is raised.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pipe_stall  input  1  decode stage cannot accept the held instruction this cycle.
- branch_taken  input  1  redirect request, valid for one cycle.
- branch_target  input  DATA_SIZE  redirect address, sampled when branch_taken=1.
- im_req  output  1  instruction-memory request.
- im_addr  output  DATA_SIZE  request address; always equals pc.
- im_ack  input  1  memory returns data this cycle; only meaningful while im_req=1.
- im_rdata  input  DATA_SIZE  fetched instruction, valid with im_ack.
- pc  output  DATA_SIZE  address of the next or outstanding fetch.
- past_pc  output  DATA_SIZE  address of the instruction on instr_out.
- instr_out  output  DATA_SIZE  held instruction.
- instr_valid  output  1  instr_out holds a live instruction.
- bus_stall  output  1  request outstanding with no ack this cycle (im_req & ~im_ack).
- instruction_stall  output  1  instr_valid & pipe_stall.
- bus_err  output  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=S_IDLE, pc=past_pc=RESET_PC, instr_out=NOP_INSTR.
  - instr_valid=0, im_req=0, bus_err=0.
  - flush_pend=0, wait_cnt=0, tgt_buf=0.
- Reset mid-request abandons the request; any later im_ack is ignored because im_req=0.
- FSM states: S_IDLE, S_FETCH, S_VALID. All registers update on the rising clk edge.
- S_IDLE:
  - im_req=0.
  - Next state is always S_FETCH, so the first request appears on the second clock after reset release.
  - branch_taken is ignored in this state.
- S_FETCH:
  - im_req=1, im_addr=pc. im_ack may arrive in the first or any later cycle.
  - ack=1, flush_pend=0, branch_taken=0: instr_out<=im_rdata, instr_valid<=1, past_pc<=pc, pc<=pc+4 (modulo 2^DATA_SIZE, wraps silently), go to S_VALID.
  - ack=1 with branch_taken=1 or flush_pend=1: discard im_rdata. pc<=branch_target if branch_taken, else tgt_buf. Clear flush_pend, stay in S_FETCH; the new request is issued on the next cycle.
  - ack=0 with branch_taken=1: flush_pend<=1, tgt_buf<=branch_target, pc unchanged (the outstanding address must stay stable). A later branch overwrites tgt_buf.
- S_VALID:
  - im_req=0, instr_valid=1.
  - Consumption cycle is instr_valid & ~pipe_stall.
  - branch_taken (highest priority, regardless of pipe_stall): instr_valid<=0, instr_out<=NOP_INSTR, pc<=branch_target, go to S_FETCH.
  - pipe_stall=1: hold every register, stay in S_VALID.
  - Otherwise (consumed): instr_valid<=0, go to S_FETCH.
- Priority: branch_taken > im_ack > pipe_stall.
- Watchdog:
  - wait_cnt increments each S_FETCH cycle with im_ack=0 and saturates at TIMEOUT.
  - wait_cnt clears on ack or on leaving S_FETCH.
  - When wait_cnt reaches TIMEOUT, bus_err<=1 and stays high until reset. The request continues.
- All outputs except bus_stall and instruction_stall are registered. bus_stall and instruction_stall are combinational from state and inputs.
- Throughput: one instruction per 2 cycles with zero-wait memory.

Test Plan:
- Reset release, im_ack tied 1, pipe_stall=0:
  - im_req first high on cycle 2.
  - instr_valid pulses every 2 cycles.
  - past_pc sequence 0,4,8; pc leads by 4.
- im_ack delayed 3 cycles at pc=0x10:
  - bus_stall=1 for 3 cycles, pc and im_addr held at 0x10.
  - On ack, instr_out=im_rdata, past_pc=0x10, pc=0x14.
- Instruction held with pipe_stall=1 for 4 cycles:
  - instruction_stall=1, and instr_out, past_pc and pc unchanged.
  - im_req=0 throughout.
  - Release of pipe_stall leads to S_FETCH the next cycle.
- branch_taken to 0x100 while waiting at pc=0x20, ack 2 cycles later:
  - Data discarded, instr_valid stays 0.
  - Next request im_addr=0x100.
- branch_taken to 0x200 in S_VALID with pipe_stall=1:
  - instr_valid=0, instr_out=0x13, next im_addr=0x200.
- im_ack held 0 for 20 cycles:
  - bus_err rises after 15 wait cycles and stays 1 after ack.
  - rst=0 mid-wait clears bus_err and im_req, and pc=RESET_PC.
